// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR receive checker: default sizes, FSM states
// and the LFSR tap set.
package lfsr_pkg;

  localparam int WIDTH_DEF     = 4;
  localparam int GEN_STEPS_DEF = 8;
  localparam int TIMEOUT_DEF   = 32;

  // Feedback taps live on register bits 2, 1 and 0.
  localparam logic [2:0] TAP_MASK = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_CHECK  = 2'd2
  } state_e;

endpackage

// File: rtl/lfsr4_gen.sv
// LFSR register plus step counter; shifts right with feedback into the MSB
// until GEN_STEPS steps have been applied since the last load.
module lfsr4_gen
  import lfsr_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int GEN_STEPS = GEN_STEPS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             step_en,
  output logic [WIDTH-1:0] value,
  output logic             steps_done
);

  localparam int SW = $clog2(GEN_STEPS + 1);
  localparam logic [SW-1:0] STEPS_MAX = SW'(GEN_STEPS);

  logic [WIDTH-1:0] value_q, value_d;
  logic [SW-1:0]    steps_q, steps_d;
  logic             fb;

  assign fb = ^(value_q[2:0] & TAP_MASK);

  always_comb begin
    value_d = value_q;
    steps_d = steps_q;
    if (load) begin
      value_d = seed;
      steps_d = '0;
    end else if (step_en && (steps_q != STEPS_MAX)) begin
      value_d = {fb, value_q[WIDTH-1:1]};
      steps_d = steps_q + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
      steps_q <= '0;
    end else begin
      value_q <= value_d;
      steps_q <= steps_d;
    end
  end

  assign value      = value_q;
  assign steps_done = (steps_q == STEPS_MAX);

endmodule

// File: rtl/lfsr_rx_checker.sv
// Receives WIDTH serial bits (LSB first) and compares them against an LFSR
// word derived from a seed; reports match/error/timeout as one-cycle pulses.
// Serial handshake: ser_in is taken on every ACTIVE cycle with ser_valid=1
// until WIDTH bits are held; there is no backpressure.
module lfsr_rx_checker
  import lfsr_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int GEN_STEPS = GEN_STEPS_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [WIDTH-1:0] seed,
  input  logic             ser_in,
  input  logic             ser_valid,
  output logic             busy,
  output logic             done,
  output logic             match,
  output logic             error,
  output logic             timeout,
  output logic [WIDTH-1:0] rx_word,
  output logic [WIDTH-1:0] exp_word,
  output logic [7:0]       err_cnt,
  output logic [1:0]       dbg_state
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] BITS_MAX = BW'(WIDTH);
  localparam logic [CW-1:0] CYC_LAST = CW'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]    cyc_q, cyc_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic             done_q, done_d, match_q, match_d;
  logic             error_q, error_d, timeout_q, timeout_d;
  logic [7:0]       err_q, err_d;
  logic             gen_load, gen_step, gen_done;
  logic [WIDTH-1:0] gen_value;

  lfsr4_gen #(
    .WIDTH     (WIDTH),
    .GEN_STEPS (GEN_STEPS)
  ) u_gen (
    .clk        (CLK),
    .rst        (RST),
    .load       (gen_load),
    .seed       (seed),
    .step_en    (gen_step),
    .value      (gen_value),
    .steps_done (gen_done)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    cyc_d     = cyc_q;
    rx_d      = rx_q;
    done_d    = 1'b0;
    match_d   = 1'b0;
    error_d   = 1'b0;
    timeout_d = 1'b0;
    err_d     = err_q;
    gen_load  = 1'b0;
    gen_step  = 1'b0;
    case (state_q)
      ST_IDLE, ST_ACTIVE: begin
        // A start in ACTIVE is a silent restart: same effect as from IDLE.
        if (start) begin
          gen_load  = 1'b1;
          rx_d      = '0;
          bit_cnt_d = '0;
          cyc_d     = '0;
          state_d   = ST_ACTIVE;
        end else if (state_q == ST_ACTIVE) begin
          gen_step = 1'b1;
          cyc_d    = cyc_q + CW'(1);
          if (ser_valid && (bit_cnt_q != BITS_MAX)) begin
            rx_d      = rx_q | (WIDTH'(ser_in) << bit_cnt_q);
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
          if (gen_done && (bit_cnt_q == BITS_MAX)) begin
            state_d = ST_CHECK;
          end else if (cyc_q == CYC_LAST) begin
            timeout_d = 1'b1;
            error_d   = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      ST_CHECK: begin
        done_d  = 1'b1;
        match_d = (rx_q == gen_value);
        error_d = (rx_q != gen_value);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (error_d && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      cyc_q     <= '0;
      rx_q      <= '0;
      done_q    <= 1'b0;
      match_q   <= 1'b0;
      error_q   <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      cyc_q     <= cyc_d;
      rx_q      <= rx_d;
      done_q    <= done_d;
      match_q   <= match_d;
      error_q   <= error_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
    end
  end

  assign busy      = (state_q == ST_ACTIVE);
  assign done      = done_q;
  assign match     = match_q;
  assign error     = error_q;
  assign timeout   = timeout_q;
  assign rx_word   = rx_q;
  assign exp_word  = gen_value;
  assign err_cnt   = err_q;
  assign dbg_state = state_q;

endmodule
